// File: rtl/gearbox_dn.sv
// gearbox_dn: down-converting gearbox from IN_W-bit input words to OUT_W-bit
// output words. Bits enter at buffer position fill and leave from bit 0, so
// bit order is preserved end to end.
// Optional feature: define GEARBOX_DN_FLUSH_EN to enable the FLUSH state,
// which drains a partial residue as a zero-padded word marked with dout_last.
module gearbox_dn #(
    parameter int IN_W  = 132,
    parameter int OUT_W = 128,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din,
    output logic             din_ready,
    input  logic             dout_ready,
    output logic             dout_valid,
    output logic [OUT_W-1:0] dout,
    output logic             dout_last,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [CNT_W-1:0] fill_level
);

    localparam int BUF_W = IN_W + OUT_W;

    localparam logic [CNT_W-1:0] C_IN_W  = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] C_OUT_W = CNT_W'(OUT_W);
    localparam logic [CNT_W:0]   C_ROOM  = (CNT_W+1)'(BUF_W);
    localparam logic [CNT_W:0]   C_IN_WX = (CNT_W+1)'(IN_W);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_fill;

    logic             w_state;
    logic             w_inFire;
    logic             w_outFire;
    logic             w_fullWord;
    logic [CNT_W-1:0] w_fillAfter;
    logic [CNT_W:0]   w_fillNeed;
    logic [CNT_W-1:0] w_fillNext;
    logic [BUF_W-1:0] w_bufNext;

    // A full word is available whenever at least OUT_W bits are buffered.
    assign w_fullWord = (r_fill >= C_OUT_W);

    // In FLUSH any non-empty buffer is presented; a residue relies on the
    // invariant that bits above fill are zero to produce the zero padding.
    assign dout_valid = (w_state == ST_FLUSH) ? (r_fill != '0) : w_fullWord;
    assign w_outFire  = dout_valid & dout_ready;

    // A residue word empties the buffer completely when it is taken.
    assign w_fillAfter = !w_outFire ? r_fill :
                         (w_fullWord ? (r_fill - C_OUT_W) : '0);

    assign w_fillNeed = {1'b0, w_fillAfter} + C_IN_WX;
    assign din_ready  = (w_state == ST_RUN) && (w_fillNeed <= C_ROOM);
    assign w_inFire   = din_valid & din_ready;

    assign w_fillNext = w_fillAfter + (w_inFire ? C_IN_W : '0);

    assign dout       = r_buf[OUT_W-1:0];
    assign fill_level = r_fill;

    // Shift out the consumed word, then append the new word just above the
    // bits that remain.
    always_comb begin
        w_bufNext = w_outFire ? (r_buf >> OUT_W) : r_buf;
        if (w_inFire) begin
            w_bufNext = w_bufNext | ({{OUT_W{1'b0}}, din} << w_fillAfter);
        end
    end

    // Buffer and fill counter; a clear overrides any concurrent transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else if (sync_clr) begin
            r_buf  <= '0;
            r_fill <= '0;
        end else begin
            r_buf  <= w_bufNext;
            r_fill <= w_fillNext;
        end
    end

`ifdef GEARBOX_DN_FLUSH_EN
    logic r_state;
    logic r_clrDone;

    // RUN/FLUSH control; a clear during a pending drain still reports
    // completion one cycle later through r_clrDone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_clrDone <= 1'b0;
        end else if (sync_clr) begin
            r_state   <= ST_RUN;
            r_clrDone <= (r_state == ST_FLUSH) && (r_fill != '0);
        end else begin
            r_clrDone <= 1'b0;
            if ((r_state == ST_RUN) && flush_req) begin
                r_state <= ST_FLUSH;
            end else if ((r_state == ST_FLUSH) && (r_fill == '0)) begin
                r_state <= ST_RUN;
            end
        end
    end

    assign w_state    = r_state;
    assign dout_last  = (r_state == ST_FLUSH) && (r_fill != '0) && !w_fullWord;
    assign flush_done = ((r_state == ST_FLUSH) && (r_fill == '0)) || r_clrDone;
`else
    logic w_unused;

    assign w_unused   = flush_req;
    assign w_state    = ST_RUN;
    assign dout_last  = 1'b0;
    assign flush_done = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_dn.sv
// tb_gearbox_dn: self-checking bench for gearbox_dn. A bit-queue model of the
// buffered stream predicts every output each cycle; table vectors and short
// hand-written sequences add explicit expectations for the corner cases.
module tb_gearbox_dn;

    localparam int IN_W  = 132;
    localparam int OUT_W = 128;
    localparam int CNT_W = 9;
    localparam int BUF_W = IN_W + OUT_W;

`ifdef GEARBOX_DN_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sync_clr = 1'b0;
    logic             din_valid = 1'b0;
    logic [IN_W-1:0]  din = '0;
    logic             din_ready;
    logic             dout_ready = 1'b0;
    logic             dout_valid;
    logic [OUT_W-1:0] dout;
    logic             dout_last;
    logic             flush_req = 1'b0;
    logic             flush_done;
    logic [CNT_W-1:0] fill_level;

    int checks = 0;
    int failures = 0;

    bit mQ[$];
    bit mFlush = 1'b0;
    bit mClrDone = 1'b0;
    bit mLastIn = 1'b0;

    logic [CNT_W-1:0] sFill;
    logic             sRdy;
    logic             sVld;
    logic             sLast;
    logic             sFd;
    logic [OUT_W-1:0] sDout;

    typedef struct {
        logic dinValid;
        logic doutReady;
        int   expFill;
        logic expRdy;
        logic expVld;
    } vec_t;

    vec_t vecs[36];

    gearbox_dn #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_last  (dout_last),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual,
                               input logic [OUT_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] randWord();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[IN_W-1:0];
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare every
    // output with the queue model, then advance the model at the rising edge.
    task automatic applyStimulus(input logic iv, input logic ir, input logic ic,
                                 input logic ifr, input logic [IN_W-1:0] id);
        int n;
        int after;
        logic [OUT_W-1:0] eDout;
        logic eVld, eLast, eFd, eRdy, outF, inF;
        @(negedge clk);
        din_valid  = iv;
        dout_ready = ir;
        sync_clr   = ic;
        flush_req  = ifr;
        din        = id;
        #1;
        n = mQ.size();
        eDout = '0;
        for (int i = 0; i < OUT_W && i < n; i++) eDout[i] = mQ[i];
        if (mFlush) begin
            eVld  = (n > 0);
            eLast = (n > 0) && (n < OUT_W);
            eFd   = (n == 0);
        end else begin
            eVld  = (n >= OUT_W);
            eLast = 1'b0;
            eFd   = mClrDone;
        end
        outF  = eVld && ir;
        after = outF ? ((n >= OUT_W) ? n - OUT_W : 0) : n;
        eRdy  = !mFlush && (after + IN_W <= BUF_W);
        inF   = iv && eRdy;
        sFill = fill_level; sRdy = din_ready; sVld = dout_valid;
        sLast = dout_last; sFd = flush_done; sDout = dout;
        checkOutput("model_fill", 128'(fill_level), 128'(n));
        checkOutput("model_dout_valid", 128'(dout_valid), 128'(eVld));
        checkOutput("model_din_ready", 128'(din_ready), 128'(eRdy));
        checkOutput("model_dout", dout, eDout);
        checkOutput("model_dout_last", 128'(dout_last), 128'(eLast));
        checkOutput("model_flush_done", 128'(flush_done), 128'(eFd));
        @(posedge clk);
        mLastIn = inF;
        if (ic) begin
            mClrDone = mFlush && (n != 0);
            mFlush   = 1'b0;
            mQ.delete();
        end else begin
            mClrDone = 1'b0;
            if (outF) for (int i = 0; i < OUT_W && mQ.size() > 0; i++) void'(mQ.pop_front());
            if (inF) for (int i = 0; i < IN_W; i++) mQ.push_back(id[i]);
            if (mFlush && n == 0) mFlush = 1'b0;
            else if (!mFlush && ifr && FLUSH_EN) mFlush = 1'b1;
        end
    endtask

    // Assert reset with idle inputs, check reset values, empty the model.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0; dout_ready = 1'b0; sync_clr = 1'b0; flush_req = 1'b0; din = '0;
        #1;
        checkOutput("rst_dout_valid", 128'(dout_valid), 128'(0));
        checkOutput("rst_din_ready", 128'(din_ready), 128'(1));
        checkOutput("rst_fill", 128'(fill_level), 128'(0));
        checkOutput("rst_dout", dout, 128'(0));
        checkOutput("rst_last_done", 128'({dout_last, flush_done}), 128'(0));
        mQ.delete();
        mFlush = 1'b0;
        mClrDone = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [IN_W-1:0] word;
        logic [IN_W-1:0] held;

        for (int i = 0; i < 36; i++) begin
            vecs[i].dinValid  = 1'b1;
            vecs[i].doutReady = 1'b1;
            vecs[i].expVld    = (i != 0);
            vecs[i].expFill   = (i == 0) ? 0 : 132 + 4 * ((i - 1) % 33);
            vecs[i].expRdy    = (vecs[i].expFill != 260);
        end

        doReset();

        // Continuous streaming with incrementing words.
        word = 132'd1;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(vecs[i].dinValid, vecs[i].doutReady, 1'b0, 1'b0, word);
            checkOutput($sformatf("tbl_fill_%0d", i), 128'(sFill), 128'(vecs[i].expFill));
            checkOutput($sformatf("tbl_rdy_%0d", i), 128'(sRdy), 128'(vecs[i].expRdy));
            checkOutput($sformatf("tbl_vld_%0d", i), 128'(sVld), 128'(vecs[i].expVld));
            if (mLastIn) word = word + 1'b1;
        end

        // Backpressure: one word buffered, sink stalled for 10 cycles.
        doReset();
        held = randWord();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, held);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randWord());
            checkOutput("bp_din_ready", 128'(sRdy), 128'(0));
            checkOutput("bp_dout_stable", sDout, held[OUT_W-1:0]);
        end
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, randWord());

        // Clear at fill 200 with concurrent fires.
        doReset();
        for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, randWord());
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, randWord());
        checkOutput("clr_fill_before", 128'(sFill), 128'(200));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("clr_fill_after", 128'(sFill), 128'(0));
        checkOutput("clr_vld_after", 128'(sVld), 128'(0));

        // Flush of a 4-bit residue.
        doReset();
        word = '0;
        word[IN_W-1:OUT_W] = 4'hF;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, word);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        checkOutput("fl_fill_residue", 128'(sFill), 128'(4));
`ifdef GEARBOX_DN_FLUSH_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("fl_last_word", sDout, 128'hF);
        checkOutput("fl_last_flag", 128'({sVld, sLast}), 128'(3));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("fl_done_pulse", 128'(sFd), 128'(1));
        checkOutput("fl_rdy_in_flush", 128'(sRdy), 128'(0));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("fl_rdy_after", 128'(sRdy), 128'(1));
        checkOutput("fl_done_cleared", 128'(sFd), 128'(0));

        // Clear while a drain is pending still reports completion.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, randWord());
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, '0);
        checkOutput("flclr_rdy_in_flush", 128'(sRdy), 128'(0));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("flclr_done_pulse", 128'(sFd), 128'(1));
        checkOutput("flclr_fill", 128'(sFill), 128'(0));
`else
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
            checkOutput("nofl_last_done", 128'({sLast, sFd}), 128'(0));
            checkOutput("nofl_residue_kept", 128'(sFill), 128'(4));
        end
`endif

        // Randomized traffic with an asynchronous reset in the middle.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 100) == 0,
                          ($urandom % 40) == 0, randWord());
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                checkOutput("async_rst_fill", 128'(fill_level), 128'(0));
                checkOutput("async_rst_vld", 128'(dout_valid), 128'(0));
                doReset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gearbox_dn.md
GEARBOX_DN -- requirements
Module: gearbox_dn

Interface
REQ-001 Parameter IN_W, default 132, input word width in bits; SHALL satisfy OUT_W < IN_W < 2*OUT_W.
REQ-002 Parameter OUT_W, default 128, output word width in bits.
REQ-003 Parameter CNT_W, default 9, fill counter width; SHALL hold values 0..IN_W+OUT_W.
REQ-004 clk  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 sync_clr  input  1  synchronous clear of buffered data.
REQ-007 din_valid  input  1  input word valid.
REQ-008 din  input  IN_W  input word; bit 0 is transmitted first.
REQ-009 din_ready  output  1  block accepts din this cycle.
REQ-010 dout_ready  input  1  sink accepts dout this cycle.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout  output  OUT_W  output word; bit 0 is transmitted first.
REQ-013 dout_last  output  1  marks a zero-padded flush word.
REQ-014 flush_req  input  1  single-cycle request to drain the residue.
REQ-015 flush_done  output  1  single-cycle pulse when a drain completes.
REQ-016 fill_level  output  CNT_W  number of valid bits currently buffered.

Function
REQ-017 The block SHALL hold a BUF_W = IN_W+OUT_W bit buffer and a fill counter; dout SHALL equal buffer[OUT_W-1:0].
REQ-018 Define in_fire = din_valid & din_ready, out_fire = dout_valid & dout_ready, and fill_after = fill - (out_fire ? OUT_W : 0).
REQ-019 In RUN, dout_valid SHALL be (fill >= OUT_W), derived only from registered state.
REQ-020 In RUN, din_ready SHALL be (fill_after + IN_W <= BUF_W); the combinational path from dout_ready to din_ready is permitted.
REQ-021 The next buffer value SHALL be (buffer >> (out_fire ? OUT_W : 0)), OR-ed with (din << fill_after) when in_fire.
REQ-022 The next fill SHALL be fill_after + (in_fire ? IN_W : 0).
REQ-023 Bits above fill SHALL always read zero.
REQ-024 Simultaneous in_fire and out_fire in one cycle SHALL both take effect.
REQ-025 Bit order SHALL be preserved end to end, with no loss or duplication.
REQ-026 For continuous din_valid=1 and dout_ready=1 with defaults, din_ready SHALL be low exactly one cycle in every 33 once streaming.
REQ-027 The FSM SHALL have two states, RUN and FLUSH.
REQ-028 RUN->FLUSH SHALL occur on flush_req.
REQ-029 In FLUSH, din_ready SHALL be 0.
REQ-030 In FLUSH, words with fill >= OUT_W SHALL drain normally.
REQ-031 In FLUSH, when 0 < fill < OUT_W, dout_valid=1, dout_last=1 and the upper bits SHALL be zero; on out_fire fill SHALL become 0.
REQ-032 In FLUSH, when fill==0, the block SHALL return to RUN and pulse flush_done for one cycle.
REQ-033 flush_req received while already in FLUSH SHALL be ignored.
REQ-034 sync_clr SHALL force fill=0, buffer=0, state=RUN on the next edge, overriding all concurrent fires and flush.
REQ-035 In FLUSH, sync_clr SHALL complete the drain: state=RUN and flush_done pulses.

Reset
REQ-036 rst_n low SHALL asynchronously set fill=0, buffer=0, state=RUN.
REQ-037 Reset output values SHALL be: dout_valid=0, dout_last=0, flush_done=0, dout=0, fill_level=0, din_ready=1.
REQ-038 Reset asserted mid-stream SHALL discard all buffered bits, with no partial word emitted after release.

Configuration
REQ-039 Macro GEARBOX_DN_FLUSH_EN defined: the FLUSH state and behaviour of REQ-028..REQ-035 SHALL be present.
REQ-040 Macro GEARBOX_DN_FLUSH_EN undefined: flush_req SHALL be ignored, the FSM SHALL remain in RUN, and dout_last and flush_done SHALL be tied to 0; ports SHALL remain unchanged.

Verification
REQ-041 Reset: release rst_n with din_valid=0 -> dout_valid=0, din_ready=1, fill_level=0.
REQ-042 Streaming: dout_ready=1, incrementing 132-bit words on every ready -> fill_level follows 132, 136, ... 260, then 132; din_ready is low exactly on cycle 33 after the first accept; the concatenated output bitstream equals the input bitstream.
REQ-043 Backpressure: fill=132, dout_ready=0 for 10 cycles -> din_ready=0 and dout stable throughout; release -> resumes with no bit loss.
REQ-044 Flush: one word 0xF<<128 accepted, one output drained (fill=4), then flush_req -> next word dout=0x...000F, dout_last=1; the following cycle flush_done=1, then din_ready=1.
REQ-045 Clear: fill=200 with sync_clr, din_valid and dout_ready all 1 in the same cycle -> next cycle fill_level=0, dout_valid=0.
REQ-046 Macro off: the flush_req sequence of REQ-044 -> no dout_last and no flush_done; the 4 residue bits stay buffered.
